// File: rtl/uart_xcvr_if.sv
// uart_xcvr_if: byte-level TX/RX valid/ready handshakes between the core logic and uart_xcvr.
interface uart_xcvr_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_parity_err;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_parity_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART, independent TX and RX channels with byte-level handshakes.
// Define UART_PARITY_EN to add a parity bit (even/odd selected by PARITY_ODD) on both channels.
module uart_xcvr #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    uart_xcvr_if.slave bus,
    output logic       uart_tx,
    input  logic       uart_rx
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1) begin : gBadParams
        $error("uart_xcvr: illegal parameter set");
    end

    localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3,
                           TX_STOP = 3'd4;
    localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3,
                           RX_STOP = 3'd4, RX_BREAK = 3'd5;

    // ---------------- TX ----------------
    logic [2:0]           txState;
    logic [CW-1:0]        txCnt;
    logic [3:0]           txBit;
    logic [DATA_BITS-1:0] txShift;
`ifdef UART_PARITY_EN
    logic                 txPar;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txState <= TX_IDLE;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
`ifdef UART_PARITY_EN
            txPar   <= 1'b0;
`endif
            uart_tx <= 1'b1;
        end else if (txState == TX_IDLE) begin
            if (bus.tx_valid) begin
                txState <= TX_START;
                txShift <= bus.tx_data;
`ifdef UART_PARITY_EN
                txPar   <= (^bus.tx_data) ^ PARITY_ODD[0];
`endif
                txCnt   <= '0;
                uart_tx <= 1'b0;
            end
        end else if (txCnt != BIT_LAST) begin
            txCnt <= txCnt + 1'b1;
        end else begin
            // Bit period complete: drive the next line level in the same clk as the state change.
            txCnt <= '0;
            case (txState)
                TX_START: begin
                    txState <= TX_DATA;
                    txBit   <= '0;
                    uart_tx <= txShift[0];
                end
                TX_DATA: begin
                    if (txBit == DATA_LAST) begin
                        txBit   <= '0;
`ifdef UART_PARITY_EN
                        txState <= TX_PARITY;
                        uart_tx <= txPar;
`else
                        txState <= TX_STOP;
                        uart_tx <= 1'b1;
`endif
                    end else begin
                        txBit   <= txBit + 1'b1;
                        txShift <= txShift >> 1;
                        uart_tx <= txShift[1];
                    end
                end
                TX_PARITY: begin
                    txState <= TX_STOP;
                    uart_tx <= 1'b1;
                end
                TX_STOP: begin
                    if (txBit == STOP_LAST) txState <= TX_IDLE;
                    else                    txBit   <= txBit + 1'b1;
                end
                default: begin
                    txState <= TX_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_ready = (txState == TX_IDLE);
    assign bus.tx_busy  = (txState != TX_IDLE);

    // ---------------- RX ----------------
    logic [1:0]           rxSync;
    logic                 rxBit;
    logic [2:0]           rxState;
    logic [CW-1:0]        rxCnt;
    logic [3:0]           rxIdx;
    logic [DATA_BITS-1:0] rxShift;
    logic [DATA_BITS-1:0] rxData;
    logic                 rxValid;
    logic                 rxFrameErr;
    logic                 rxOverrun;
    logic                 rxParityErr;
`ifdef UART_PARITY_EN
    logic                 rxPar;
`endif

    assign rxBit = rxSync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxSync      <= 2'b11;
            rxState     <= RX_IDLE;
            rxCnt       <= '0;
            rxIdx       <= '0;
            rxShift     <= '0;
            rxData      <= '0;
            rxValid     <= 1'b0;
            rxFrameErr  <= 1'b0;
            rxOverrun   <= 1'b0;
            rxParityErr <= 1'b0;
`ifdef UART_PARITY_EN
            rxPar       <= 1'b0;
`endif
        end else begin
            rxSync      <= {rxSync[0], uart_rx};
            rxFrameErr  <= 1'b0;
            rxOverrun   <= 1'b0;
            rxParityErr <= 1'b0;
            if (rxValid && bus.rx_ready) rxValid <= 1'b0;

            case (rxState)
                RX_IDLE: begin
                    rxCnt <= '0;
                    if (!rxBit) rxState <= RX_START;
                end
                RX_START: begin
                    if (rxCnt == HALF_LAST) begin
                        rxCnt   <= '0;
                        rxIdx   <= '0;
                        rxState <= rxBit ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxShift <= {rxBit, rxShift[DATA_BITS-1:1]};
                        if (rxIdx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            rxState <= RX_PARITY;
`else
                            rxState <= RX_STOP;
`endif
                        end else begin
                            rxIdx <= rxIdx + 1'b1;
                        end
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt   <= '0;
                        rxPar   <= rxBit;
                        rxState <= RX_STOP;
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rxCnt == BIT_LAST) begin
                        rxCnt <= '0;
                        if (rxBit) begin
                            // Back to IDLE at mid-stop leaves half a bit to catch the next start.
                            rxState <= RX_IDLE;
                            if (rxValid && !bus.rx_ready) begin
                                rxOverrun <= 1'b1;
                            end else begin
                                rxData  <= rxShift;
                                rxValid <= 1'b1;
`ifdef UART_PARITY_EN
                                rxParityErr <= ((^rxShift) ^ rxPar) != PARITY_ODD[0];
`endif
                            end
                        end else begin
                            rxFrameErr <= 1'b1;
                            rxState    <= RX_BREAK;
                        end
                    end else begin
                        rxCnt <= rxCnt + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rxBit) rxState <= RX_IDLE;
                end
                default: rxState <= RX_IDLE;
            endcase
        end
    end

    assign bus.rx_data       = rxData;
    assign bus.rx_valid      = rxValid;
    assign bus.rx_frame_err  = rxFrameErr;
    assign bus.rx_overrun    = rxOverrun;
    assign bus.rx_parity_err = rxParityErr;
endmodule
